// File: rtl/rob_dispatch_ctrl.sv
// rob_dispatch_ctrl: dispatch scheduler between decode/rename and the ROB.
// Each cycle it grants an in-order prefix of the 4-wide decode group. The
// grant is bounded by ROB free entries, IQ credits and free physical
// registers. It also tracks occupancy/credits and sequences flushes.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_fe_valid[3:0]     decode-group valid mask (leading run of ones counts)
//   i_fe_rd_en[3:0]     instruction k needs a physical destination register
//   i_preg_avail[5:0]   free physical registers this cycle
//   i_retire_count[2:0] ROB entries retired this cycle
//   i_iq_release[2:0]   IQ slots freed this cycle
//   i_flush             flush request pulse
//   o_ins_count[2:0]    instructions dispatched this cycle (combinational)
//   o_fe_accept[2:0]    same as o_ins_count (combinational)
//   o_preg_alloc[2:0]   physical registers taken this cycle (combinational)
//   o_rob_free[4:0]     ROB free entries (registered)
//   o_iq_credits[3:0]   IQ credits (registered)
//   o_stall             valid instructions left unaccepted (combinational)
//   o_flushing          controller is in FLUSH (registered)
//   o_err               sticky accounting error (registered)
module rob_dispatch_ctrl #(
   parameter int unsigned ROB_DEPTH    = 16,
   parameter int unsigned IQ_DEPTH     = 12,
   parameter int unsigned FLUSH_CYCLES = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_fe_valid,
   input  logic [3:0] i_fe_rd_en,
   input  logic [5:0] i_preg_avail,
   input  logic [2:0] i_retire_count,
   input  logic [2:0] i_iq_release,
   input  logic       i_flush,
   output logic [2:0] o_ins_count,
   output logic [2:0] o_fe_accept,
   output logic [2:0] o_preg_alloc,
   output logic [4:0] o_rob_free,
   output logic [3:0] o_iq_credits,
   output logic       o_stall,
   output logic       o_flushing,
   output logic       o_err
);

   localparam int unsigned OCC_W  = 5;
   localparam int unsigned CRED_W = 4;
   localparam int unsigned CNT_W  = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [OCC_W-1:0]    free_q, free_d;
   logic [CRED_W-1:0]   cred_q, cred_d;
   logic                err_q, err_d;

   logic [2:0]          lead;
   logic                stop;
   logic [2:0]          grant;
   logic [2:0]          alloc;
   logic [2:0]          pc;
   logic                blk;
   logic                dispatch_en;
   logic [OCC_W:0]      occ;
   logic [OCC_W:0]      occ_sum;
   logic [CRED_W:0]     cred_sum;

   // Grant: largest in-order prefix satisfying ROB, IQ and preg limits
   always_comb begin
      lead = '0;
      stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!stop && i_fe_valid[i]) begin
            lead = lead + 3'd1;
         end else begin
            stop = 1'b1;
         end
      end
      grant = '0;
      alloc = '0;
      pc    = '0;
      blk   = 1'b0;
      // Once one prefix length fails, every longer one fails too
      for (int k = 1; k <= 4; k++) begin
         pc = pc + {2'b00, i_fe_rd_en[k-1]};
         if (!blk && (3'(k) <= lead) && (OCC_W'(k) <= free_q) &&
             (CRED_W'(k) <= cred_q) && ({3'b000, pc} <= i_preg_avail)) begin
            grant = 3'(k);
            alloc = pc;
         end else begin
            blk = 1'b1;
         end
      end
      dispatch_en  = !i_rst && (state_q == RUN) && !i_flush;
      o_ins_count  = dispatch_en ? grant : 3'd0;
      o_fe_accept  = o_ins_count;
      o_preg_alloc = dispatch_en ? alloc : 3'd0;
      o_stall      = dispatch_en && (grant < lead);
   end

   // Next state, countdown and counter updates with guard-bit clamping
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      free_d   = free_q;
      cred_d   = cred_q;
      err_d    = err_q;
      occ      = (OCC_W+1)'(ROB_DEPTH) - {1'b0, free_q};
      occ_sum  = occ + (OCC_W+1)'(o_ins_count);
      cred_sum = {1'b0, cred_q} - (CRED_W+1)'(o_ins_count)
                 + (CRED_W+1)'(i_iq_release);

      case (state_q)
         RUN: begin
            if (i_flush) begin
               state_d = FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES);
            end
         end
         FLUSH: begin
            if (i_flush) begin
               cnt_d = CNT_W'(FLUSH_CYCLES);
            end else if (cnt_q <= CNT_W'(1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase

      if (i_flush) begin
         free_d = OCC_W'(ROB_DEPTH);
         cred_d = CRED_W'(IQ_DEPTH);
      end else begin
         if ((OCC_W+1)'(i_retire_count) > occ_sum) begin
            err_d  = 1'b1;
            free_d = OCC_W'(ROB_DEPTH);
         end else begin
            free_d = OCC_W'((OCC_W+1)'(ROB_DEPTH) - (occ_sum - (OCC_W+1)'(i_retire_count)));
         end
         if (cred_sum > (CRED_W+1)'(IQ_DEPTH)) begin
            err_d  = 1'b1;
            cred_d = CRED_W'(IQ_DEPTH);
         end else begin
            cred_d = CRED_W'(cred_sum);
         end
      end
   end

   // State and counter registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         free_q  <= OCC_W'(ROB_DEPTH);
         cred_q  <= CRED_W'(IQ_DEPTH);
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         free_q  <= free_d;
         cred_q  <= cred_d;
         err_q   <= err_d;
      end
   end

   assign o_rob_free   = free_q;
   assign o_iq_credits = cred_q;
   assign o_flushing   = (state_q == FLUSH);
   assign o_err        = err_q;

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// tb_rob_dispatch_ctrl: directed plus randomized checks of rob_dispatch_ctrl
// against an arithmetic reference model of ROB occupancy, IQ credits,
// flush countdown and the sticky error flag.
module tb_rob_dispatch_ctrl;

   localparam int ROB_DEPTH = 16;
   localparam int IQ_DEPTH  = 12;
   localparam int FLUSH_CYC = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] fe_valid;
   logic [3:0] fe_rd_en;
   logic [5:0] preg_avail;
   logic [2:0] retire;
   logic [2:0] iq_rel;
   logic       flush;
   logic [2:0] ins_count, fe_accept, preg_alloc;
   logic [4:0] rob_free;
   logic [3:0] iq_credits;
   logic       stall, flushing, err;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_occ, m_cred, m_flush_left, m_err;
   // last observed combinational outputs, for directed checks
   int obs_ins, obs_alloc, obs_stall;

   rob_dispatch_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_fe_valid(fe_valid), .i_fe_rd_en(fe_rd_en),
      .i_preg_avail(preg_avail), .i_retire_count(retire), .i_iq_release(iq_rel),
      .i_flush(flush), .o_ins_count(ins_count), .o_fe_accept(fe_accept),
      .o_preg_alloc(preg_alloc), .o_rob_free(rob_free), .o_iq_credits(iq_credits),
      .o_stall(stall), .o_flushing(flushing), .o_err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int lead_ones(input logic [3:0] v);
      int n = 0;
      while (n < 4 && v[n]) n++;
      return n;
   endfunction

   function automatic int pop_prefix(input logic [3:0] rd, input int len);
      logic [3:0] m;
      m = 4'((1 << len) - 1);
      return $countones(rd & m);
   endfunction

   // Largest legal prefix: clip by ROB and IQ room, then shrink for pregs
   function automatic int exp_grant();
      int lim;
      if (rst || flush || m_flush_left > 0) return 0;
      lim = lead_ones(fe_valid);
      if (lim > ROB_DEPTH - m_occ) lim = ROB_DEPTH - m_occ;
      if (lim > m_cred) lim = m_cred;
      while (lim > 0 && pop_prefix(fe_rd_en, lim) > int'(preg_avail)) lim--;
      return lim;
   endfunction

   task automatic set_in(input logic [3:0] v, input logic [3:0] rd, input int preg,
                         input int ret, input int rel, input logic fl, input logic r);
      fe_valid   = v;
      fe_rd_en   = rd;
      preg_avail = 6'(preg);
      retire     = 3'(ret);
      iq_rel     = 3'(rel);
      flush      = fl;
      rst        = r;
   endtask

   // One clock: check combinational grant, advance model, check registers
   task automatic cycle();
      int g, a, st, s, c;
      #3;
      g  = exp_grant();
      a  = (g > 0) ? pop_prefix(fe_rd_en, g) : 0;
      st = (!rst && !flush && m_flush_left == 0 && g < lead_ones(fe_valid)) ? 1 : 0;
      obs_ins   = int'(ins_count);
      obs_alloc = int'(preg_alloc);
      obs_stall = int'(stall);
      check("ins_count", int'(ins_count), g);
      check("fe_accept", int'(fe_accept), g);
      check("preg_alloc", int'(preg_alloc), a);
      check("stall", int'(stall), st);
      @(posedge clk);
      if (rst) begin
         m_occ = 0; m_cred = IQ_DEPTH; m_flush_left = 0; m_err = 0;
      end else if (flush) begin
         m_occ = 0; m_cred = IQ_DEPTH; m_flush_left = FLUSH_CYC;
      end else begin
         if (m_flush_left > 0) m_flush_left--;
         s = m_occ + g;
         if (int'(retire) > s) begin m_err = 1; m_occ = 0; end
         else m_occ = s - int'(retire);
         c = m_cred - g + int'(iq_rel);
         if (c > IQ_DEPTH) begin m_err = 1; c = IQ_DEPTH; end
         m_cred = c;
      end
      #1;
      check("rob_free", int'(rob_free), ROB_DEPTH - m_occ);
      check("iq_credits", int'(iq_credits), m_cred);
      check("flushing", int'(flushing), (m_flush_left > 0) ? 1 : 0);
      check("err", int'(err), m_err);
   endtask

   task automatic do_reset();
      set_in(4'h0, 4'h0, 0, 0, 0, 1'b0, 1'b1);
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int ret_max, rel_max;
      m_occ = 0; m_cred = IQ_DEPTH; m_flush_left = 0; m_err = 0;
      set_in(4'h0, 4'h0, 0, 0, 0, 1'b0, 1'b1);
      @(posedge clk); #1;
      do_reset();
      check("reset_rob_free", int'(rob_free), 16);
      check("reset_iq_credits", int'(iq_credits), 12);
      check("reset_flushing", int'(flushing), 0);

      // credits exhaust after three full groups
      set_in(4'hF, 4'hF, 63, 0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("full_group_ins", obs_ins, 4);
         check("full_group_alloc", obs_alloc, 4);
      end
      cycle();
      check("cred_empty_ins", obs_ins, 0);
      check("cred_empty_stall", obs_stall, 1);
      check("cred_empty_rob_free", int'(rob_free), 4);
      check("cred_empty_credits", int'(iq_credits), 0);

      // fill the ROB while releasing IQ slots each cycle
      do_reset();
      set_in(4'hF, 4'hF, 63, 0, 4, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle();
      check("rob_full_free", int'(rob_free), 0);
      set_in(4'hF, 4'hF, 63, 2, 0, 1'b0, 1'b0);
      cycle();
      check("rob_full_ins", obs_ins, 0);
      set_in(4'hF, 4'hF, 63, 0, 0, 1'b0, 1'b0);
      cycle();
      check("after_retire2_ins", obs_ins, 2);

      // physical register limit
      do_reset();
      set_in(4'hF, 4'hB, 2, 0, 0, 1'b0, 1'b0);
      cycle();
      check("preg_ins", obs_ins, 3);
      check("preg_alloc_lim", obs_alloc, 2);
      check("preg_stall", obs_stall, 1);

      // non-contiguous valid mask
      do_reset();
      set_in(4'hD, 4'hF, 63, 0, 0, 1'b0, 1'b0);
      cycle();
      check("noncontig_ins", obs_ins, 1);

      // flush at occupancy 9
      do_reset();
      set_in(4'hF, 4'h0, 63, 0, 0, 1'b0, 1'b0);
      cycle(); cycle();
      set_in(4'h1, 4'h0, 63, 0, 0, 1'b0, 1'b0);
      cycle();
      check("pre_flush_free", int'(rob_free), 7);
      set_in(4'hF, 4'h0, 63, 0, 0, 1'b1, 1'b0);
      cycle();
      check("flush_cycle_ins", obs_ins, 0);
      flush = 1'b0;
      for (int i = 0; i < FLUSH_CYC; i++) begin
         check("flushing_on", int'(flushing), 1);
         cycle();
         check("flushing_ins", obs_ins, 0);
      end
      check("post_flush_free", int'(rob_free), 16);
      check("post_flush_credits", int'(iq_credits), 12);
      check("post_flush_state", int'(flushing), 0);
      cycle();
      check("resume_ins", obs_ins, 4);

      // reset during flush
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      cycle();
      check("mid_flush", int'(flushing), 1);
      rst = 1'b1;
      cycle();
      check("reset_in_flush", int'(flushing), 0);
      rst = 1'b0;

      // retire beyond occupancy
      do_reset();
      set_in(4'h1, 4'h0, 63, 0, 0, 1'b0, 1'b0);
      cycle();
      set_in(4'h0, 4'h0, 63, 3, 0, 1'b0, 1'b0);
      cycle();
      check("err_set", int'(err), 1);
      check("err_free", int'(rob_free), 16);
      set_in(4'hF, 4'hF, 63, 0, 0, 1'b0, 1'b0);
      cycle(); cycle();
      check("err_sticky", int'(err), 1);
      do_reset();
      check("err_cleared", int'(err), 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         fe_valid   = 4'($urandom);
         fe_rd_en   = 4'($urandom);
         preg_avail = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                 : 6'($urandom_range(0, 4));
         ret_max = (m_occ < 4) ? m_occ : 4;
         rel_max = (IQ_DEPTH - m_cred < 4) ? IQ_DEPTH - m_cred : 4;
         retire  = 3'($urandom_range(0, ret_max));
         iq_rel  = 3'($urandom_range(0, rel_max));
         if ($urandom_range(0, 99) < 3) retire = 3'($urandom_range(0, 4));
         if ($urandom_range(0, 99) < 3) iq_rel = 3'($urandom_range(0, 4));
         flush = ($urandom_range(0, 99) < 5);
         rst   = ($urandom_range(0, 99) < 2);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
